// File: rtl/duty_recorder.sv
// Multi-channel duty-cycle recorder: captures Duty_In snapshots on button presses
// and loops them back out at a fixed prescaled rate, with a swept memory clear.
//
// state  | meaning
// PLAY   | loop recorded entries onto DC_Out, one step per PRESCALE cycles
// RECORD | live monitor on DC_Out; button edges append Duty_In to memory
// CLEAR  | zero one address per cycle across the whole memory, Busy high
module duty_recorder #(
  parameter int CH       = 2,
  parameter int DW       = 6,
  parameter int AW       = 8,
  parameter int PRESCALE = 64
) (
  input  logic             sysclk,
  input  logic             Reset_n,
  input  logic             Record_SW,
  input  logic             Clear_SW,
  input  logic [3:0]       Bt,
  input  logic [CH*DW-1:0] Duty_In,
  output logic [CH*DW-1:0] DC_Out,
  output logic [AW:0]      Length,
  output logic             Full,
  output logic             Busy
);

  localparam int              PW         = $clog2(PRESCALE);
  localparam logic [AW:0]     DEPTH_L    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]     ONE_L      = (AW+1)'(1);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_RECORD = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic       rec_s1, rec_s2;
  logic       clr_s1, clr_s2, clr_d;
  logic [3:0] bt_s1, bt_s2;
  logic       bt_or_d;
  logic       cap_ev, clr_ev;

  logic [AW-1:0]    clr_addr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [PW-1:0]    presc;
  logic [CH*DW-1:0] mem [2**AW];

  logic sweep_done, enter_clear, enter_play, new_take, wr_cap, play_run, step;

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      rec_s1  <= 1'b0;
      rec_s2  <= 1'b0;
      clr_s1  <= 1'b0;
      clr_s2  <= 1'b0;
      clr_d   <= 1'b0;
      bt_s1   <= 4'd0;
      bt_s2   <= 4'd0;
      bt_or_d <= 1'b0;
    end else begin
      rec_s1  <= Record_SW;
      rec_s2  <= rec_s1;
      clr_s1  <= Clear_SW;
      clr_s2  <= clr_s1;
      clr_d   <= clr_s2;
      bt_s1   <= Bt;
      bt_s2   <= bt_s1;
      bt_or_d <= |bt_s2;
    end
  end

  assign cap_ev = (|bt_s2) & ~bt_or_d;
  assign clr_ev = clr_s2 & ~clr_d;
  assign wptr   = Length[AW-1:0];
  assign Full   = (Length == DEPTH_L);
  assign Busy   = (state == ST_CLEAR);

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_PLAY;
    else          state <= state_nx;
  end

  // A clear event arriving during a sweep is ignored rather than restarting it.
  always_comb begin
    state_nx    = state;
    sweep_done  = (clr_addr == {AW{1'b1}});
    enter_clear = 1'b0;
    enter_play  = 1'b0;
    new_take    = 1'b0;
    wr_cap      = 1'b0;
    play_run    = 1'b0;
    step        = 1'b0;
    case (state)
      ST_PLAY: begin
        if (clr_ev)      state_nx = ST_CLEAR;
        else if (rec_s2) state_nx = ST_RECORD;
      end
      ST_RECORD: begin
        if (clr_ev)       state_nx = ST_CLEAR;
        else if (!rec_s2) state_nx = ST_PLAY;
      end
      ST_CLEAR: begin
        if (sweep_done) state_nx = rec_s2 ? ST_RECORD : ST_PLAY;
      end
      default: state_nx = ST_PLAY;
    endcase
    enter_clear = (state != ST_CLEAR) && (state_nx == ST_CLEAR);
    enter_play  = (state != ST_PLAY) && (state_nx == ST_PLAY);
    new_take    = (state == ST_PLAY) && (state_nx == ST_RECORD);
    // Staying in RECORD excludes captures coinciding with a clear or mode change.
    wr_cap      = (state == ST_RECORD) && (state_nx == ST_RECORD) && cap_ev && !Full;
    play_run    = (state == ST_PLAY) && (Length != '0);
    step        = play_run && (presc == PRESC_LAST);
  end

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_addr <= '0;
      Length   <= '0;
      rptr     <= '0;
      presc    <= '0;
    end else begin
      if (enter_clear)             clr_addr <= '0;
      else if (state == ST_CLEAR)  clr_addr <= clr_addr + AW'(1);

      if (enter_clear || new_take) Length <= '0;
      else if (wr_cap)             Length <= Length + ONE_L;

      if (enter_clear || enter_play) begin
        rptr  <= '0;
        presc <= '0;
      end else if (step) begin
        presc <= '0;
        if ({1'b0, rptr} == Length - ONE_L) rptr <= '0;
        else                                rptr <= rptr + AW'(1);
      end else if (play_run) begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      DC_Out <= '0;
    end else begin
      if (state == ST_CLEAR || state_nx == ST_CLEAR) DC_Out <= '0;
      else if (state == ST_RECORD)                   DC_Out <= Duty_In;
      else if (Length == '0)                         DC_Out <= '0;
      else                                           DC_Out <= mem[rptr];
    end
  end

  // Memory is deliberately left out of reset; Length = 0 hides stale contents.
  always_ff @(posedge sysclk) begin
    if (state == ST_CLEAR) mem[clr_addr] <= '0;
    else if (wr_cap)       mem[wptr]     <= Duty_In;
  end

endmodule

// File: tb/tb_duty_recorder.sv
// Directed bench for duty_recorder with CH=2, DW=6, AW=2, PRESCALE=4.
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_duty_recorder;

  logic        sysclk;
  logic        Reset_n;
  logic        Record_SW;
  logic        Clear_SW;
  logic [3:0]  Bt;
  logic [11:0] Duty_In;
  logic [11:0] DC_Out;
  logic [2:0]  Length;
  logic        Full;
  logic        Busy;

  int n_checks = 0;
  int n_pass   = 0;

  duty_recorder #(.CH(2), .DW(6), .AW(2), .PRESCALE(4)) dut (
    .sysclk    (sysclk),
    .Reset_n   (Reset_n),
    .Record_SW (Record_SW),
    .Clear_SW  (Clear_SW),
    .Bt        (Bt),
    .Duty_In   (Duty_In),
    .DC_Out    (DC_Out),
    .Length    (Length),
    .Full      (Full),
    .Busy      (Busy)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  function automatic logic [11:0] pk(input int x, input int y);
    logic [5:0] xs, ys;
    xs = x[5:0];
    ys = y[5:0];
    return {ys, xs};
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic capture(input int x, input int y, input logic [3:0] bits);
    Duty_In = pk(x, y);
    Bt      = bits;
    wait_neg(4);
    Bt = 4'd0;
    wait_neg(3);
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; Record_SW = 1'b0; Clear_SW = 1'b0; Bt = 4'd0; Duty_In = '0;
    wait_neg(3);
    Reset_n = 1'b1;
    wait_neg(4);
    n_checks++; if (DC_Out !== 12'h000) $display("FAIL reset_dc got=%0h exp=0", DC_Out); else n_pass++;
    n_checks++; if (Length !== 3'd0)    $display("FAIL reset_len got=%0d exp=0", Length); else n_pass++;
    n_checks++; if (Busy !== 1'b0)      $display("FAIL reset_busy got=%0b exp=0", Busy); else n_pass++;
    n_checks++; if (Full !== 1'b0)      $display("FAIL reset_full got=%0b exp=0", Full); else n_pass++;
  endtask

  task automatic test_record_play;
    logic [11:0] seq [3];
    logic found;
    seq[0] = pk(5, 9); seq[1] = pk(12, 3); seq[2] = pk(63, 0);
    Record_SW = 1'b1;
    Duty_In   = pk(5, 9);
    wait_neg(5);
    n_checks++; if (DC_Out !== pk(5, 9)) $display("FAIL live_monitor got=%0h exp=%0h", DC_Out, pk(5, 9)); else n_pass++;
    capture(5, 9, 4'b0001);
    n_checks++; if (Length !== 3'd1) $display("FAIL rec_len1 got=%0d exp=1", Length); else n_pass++;
    capture(12, 3, 4'b0010);
    capture(63, 0, 4'b1000);
    n_checks++; if (Length !== 3'd3) $display("FAIL rec_len3 got=%0d exp=3", Length); else n_pass++;
    Duty_In   = '0;
    Record_SW = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge sysclk);
      if (DC_Out === seq[0]) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL play3_start got=%0h exp=%0h", DC_Out, seq[0]); else n_pass++;
    if (found) begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (DC_Out !== seq[(i / 4) % 3])
          $display("FAIL play3_seq i=%0d got=%0h exp=%0h", i, DC_Out, seq[(i / 4) % 3]);
        else n_pass++;
        @(negedge sysclk);
      end
    end
  endtask

  task automatic test_full;
    logic [11:0] seq [4];
    logic found;
    int xs [6];
    int ys [6];
    xs = '{1, 3, 6, 8, 20, 30};
    ys = '{2, 4, 7, 10, 21, 31};
    for (int k = 0; k < 4; k++) seq[k] = pk(xs[k], ys[k]);
    Record_SW = 1'b1;
    wait_neg(5);
    n_checks++; if (Length !== 3'd0) $display("FAIL new_take_len got=%0d exp=0", Length); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      capture(xs[k], ys[k], 4'b0001 << (k % 4));
      if (k == 3) begin
        n_checks++; if (Length !== 3'd4) $display("FAIL full_len4 got=%0d exp=4", Length); else n_pass++;
        n_checks++; if (Full !== 1'b1)   $display("FAIL full_flag got=%0b exp=1", Full); else n_pass++;
      end
    end
    n_checks++; if (Length !== 3'd4) $display("FAIL full_sat got=%0d exp=4", Length); else n_pass++;
    Duty_In   = '0;
    Record_SW = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge sysclk);
      if (DC_Out === seq[0]) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL play4_start got=%0h exp=%0h", DC_Out, seq[0]); else n_pass++;
    if (found) begin
      for (int i = 0; i < 20; i++) begin
        n_checks++;
        if (DC_Out !== seq[(i / 4) % 4])
          $display("FAIL play4_seq i=%0d got=%0h exp=%0h", i, DC_Out, seq[(i / 4) % 4]);
        else n_pass++;
        @(negedge sysclk);
      end
    end
  endtask

  task automatic test_clear;
    logic found;
    int cnt;
    Clear_SW = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge sysclk);
      if (Busy === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL clear_start busy=%0b exp=1", Busy); else n_pass++;
    Clear_SW = 1'b0;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge sysclk);
    end
    n_checks++; if (cnt != 4)         $display("FAIL clear_busy_len got=%0d exp=4", cnt); else n_pass++;
    n_checks++; if (Length !== 3'd0)  $display("FAIL clear_len got=%0d exp=0", Length); else n_pass++;
    n_checks++; if (DC_Out !== 12'h0) $display("FAIL clear_dc got=%0h exp=0", DC_Out); else n_pass++;
    n_checks++; if (Full !== 1'b0)    $display("FAIL clear_full got=%0b exp=0", Full); else n_pass++;
    wait_neg(6);
    n_checks++; if (DC_Out !== 12'h0) $display("FAIL empty_play_dc got=%0h exp=0", DC_Out); else n_pass++;
  endtask

  task automatic test_capture_vs_clear;
    logic found;
    int cnt;
    Record_SW = 1'b1;
    wait_neg(5);
    capture(17, 18, 4'b0100);
    n_checks++; if (Length !== 3'd1) $display("FAIL pre_clash_len got=%0d exp=1", Length); else n_pass++;
    Duty_In  = pk(7, 7);
    Bt       = 4'b0001;
    Clear_SW = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge sysclk);
      if (Busy === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL clash_clear_start busy=%0b exp=1", Busy); else n_pass++;
    Bt       = 4'd0;
    Clear_SW = 1'b0;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge sysclk);
    end
    n_checks++; if (cnt != 4) $display("FAIL clash_busy_len got=%0d exp=4", cnt); else n_pass++;
    wait_neg(3);
    n_checks++; if (Length !== 3'd0) $display("FAIL clash_len got=%0d exp=0", Length); else n_pass++;
    capture(9, 4, 4'b0010);
    n_checks++; if (Length !== 3'd1) $display("FAIL post_clear_rec got=%0d exp=1", Length); else n_pass++;
    Duty_In   = '0;
    Record_SW = 1'b0;
    wait_neg(8);
    n_checks++; if (DC_Out !== pk(9, 4)) $display("FAIL single_play got=%0h exp=%0h", DC_Out, pk(9, 4)); else n_pass++;
    wait_neg(5);
    n_checks++; if (DC_Out !== pk(9, 4)) $display("FAIL single_wrap got=%0h exp=%0h", DC_Out, pk(9, 4)); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep;
    logic found;
    Duty_In  = pk(11, 22);
    Clear_SW = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge sysclk);
      if (Busy === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rst_sweep_start busy=%0b exp=1", Busy); else n_pass++;
    @(negedge sysclk);
    #2 Reset_n = 1'b0;
    #1;
    n_checks++; if (Busy !== 1'b0)   $display("FAIL rst_busy_async got=%0b exp=0", Busy); else n_pass++;
    n_checks++; if (Length !== 3'd0) $display("FAIL rst_len_async got=%0d exp=0", Length); else n_pass++;
    Clear_SW = 1'b0;
    wait_neg(2);
    Reset_n = 1'b1;
    wait_neg(6);
    n_checks++; if (Busy !== 1'b0)    $display("FAIL rst_busy_after got=%0b exp=0", Busy); else n_pass++;
    n_checks++; if (Length !== 3'd0)  $display("FAIL rst_len_after got=%0d exp=0", Length); else n_pass++;
    n_checks++; if (DC_Out !== 12'h0) $display("FAIL rst_play_dc got=%0h exp=0", DC_Out); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_record_play;
    test_full;
    test_clear;
    test_capture_vs_clear;
    test_reset_mid_sweep;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
